// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache with 16 one-word lines.
// Zero-wait hits, single-word memory handshake, and halt-triggered flush plus hit-count dump.
module dcache_responder #(
  parameter logic [31:0] HITCNT_ADDR = 32'h00003100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  // state | meaning
  // IDLE  | serve hits, detect misses and halt
  // WB    | write dirty victim back to memory
  // FETCH | read requested word into its line
  // FLUSH | scan lines 0..15, writing back dirty ones
  // CNTWR | write hit counter to HITCNT_ADDR
  // DONE  | flush complete, wait for reset
  typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, CNTWR, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] valid_q, dirty_q;
  logic [25:0] tag_q  [16];
  logic [31:0] data_q [16];
  logic [3:0]  scan_q;
  logic [31:0] hit_cnt;

  logic [3:0]  idx;
  logic [25:0] req_tag;
  logic        req, hit;
  logic        line_fill, line_write, clr_dirty_req, clr_dirty_scan;
  logic        scan_step, scan_clr;
  logic        unused_bits;

  assign idx         = dmemaddr[5:2];
  assign req_tag     = dmemaddr[31:6];
  assign req         = dmemREN | dmemWEN;
  assign hit         = valid_q[idx] && (tag_q[idx] == req_tag);
  assign unused_bits = ^dmemaddr[1:0];

  always_comb begin
    state_nxt      = state;
    dhit           = 1'b0;
    dmemload       = '0;
    flushed        = 1'b0;
    dREN           = 1'b0;
    dWEN           = 1'b0;
    daddr          = '0;
    dstore         = '0;
    line_fill      = 1'b0;
    line_write     = 1'b0;
    clr_dirty_req  = 1'b0;
    clr_dirty_scan = 1'b0;
    scan_step      = 1'b0;
    scan_clr       = 1'b0;
    case (state)
      IDLE: begin
        if (halt) begin
          state_nxt = FLUSH;
          scan_clr  = 1'b1;
        end else if (req) begin
          if (hit) begin
            dhit = 1'b1;
            // a simultaneous read+write request is a write
            if (dmemWEN) line_write = 1'b1;
            else         dmemload   = data_q[idx];
          end else if (valid_q[idx] && dirty_q[idx]) begin
            state_nxt = WB;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[idx], idx, 2'b00};
        dstore = data_q[idx];
        if (!dwait) begin
          clr_dirty_req = 1'b1;
          state_nxt     = FETCH;
        end
      end
      FETCH: begin
        dREN  = 1'b1;
        daddr = {dmemaddr[31:2], 2'b00};
        if (!dwait) begin
          line_fill = 1'b1;
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        if (valid_q[scan_q] && dirty_q[scan_q]) begin
          dWEN   = 1'b1;
          daddr  = {tag_q[scan_q], scan_q, 2'b00};
          dstore = data_q[scan_q];
          if (!dwait) begin
            clr_dirty_scan = 1'b1;
            scan_step      = 1'b1;
          end
        end else begin
          scan_step = 1'b1;
        end
        if (scan_step && (scan_q == 4'd15)) state_nxt = CNTWR;
      end
      CNTWR: begin
        dWEN   = 1'b1;
        daddr  = HITCNT_ADDR;
        dstore = hit_cnt;
        if (!dwait) state_nxt = DONE;
      end
      DONE: begin
        flushed = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      dirty_q <= '0;
      scan_q  <= '0;
      hit_cnt <= '0;
    end else begin
      if (dhit) hit_cnt <= hit_cnt + 32'd1;
      if (scan_clr)       scan_q <= '0;
      else if (scan_step) scan_q <= scan_q + 4'd1;
      if (line_fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (line_write)     dirty_q[idx]    <= 1'b1;
      if (clr_dirty_req)  dirty_q[idx]    <= 1'b0;
      if (clr_dirty_scan) dirty_q[scan_q] <= 1'b0;
    end
  end

  // tag/data need no reset: valid bits gate their use
  always_ff @(posedge CLK) begin
    if (line_fill) begin
      tag_q[idx]  <= req_tag;
      data_q[idx] <= dload;
    end else if (line_write) begin
      data_q[idx] <= dmemstore;
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: directed requests push expected hits and
// memory transactions; a monitor pops and compares whenever the DUT presents one.
module tb_dcache_responder;

  logic        CLK = 1'b0;
  logic        RST, halt, dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore;
  logic        dwait;
  logic [31:0] dload;

  localparam int K_RDH = 0, K_WRH = 1, K_MRD = 2, K_MWR = 3, K_FL = 4;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          mem_lat = 1;
  int          rsp_cnt = 0;
  logic        flushed_d = 1'b0;
  logic [31:0] mem [logic [31:0]];

  dcache_responder #(.HITCNT_ADDR(32'h00003100)) dut (
    .CLK(CLK), .RST(RST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic observe(input int k, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL unexpected_event: got kind %0d addr %h, expected no event", k, a);
    end else begin
      e = sb.pop_front();
      chk("event_kind", 32'(k), 32'(e.kind));
      chk("event_addr", a, e.addr);
      if (k == K_RDH || k == K_MWR) chk("event_data", d, e.data);
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctl"},      {28'd0, dhit, flushed, dREN, dWEN}, 32'd0);
    chk({name, "_daddr"},    daddr, 32'd0);
    chk({name, "_dstore"},   dstore, 32'd0);
    chk({name, "_dmemload"}, dmemload, 32'd0);
  endtask

  // issue one request and hold it until dhit; mem_cyc counts cycles with memory activity
  task automatic do_req(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] data, output int mem_cyc);
    logic got;
    got = 1'b0;
    mem_cyc = 0;
    @(posedge CLK); #1;
    dmemREN = ren; dmemWEN = wen; dmemaddr = addr; dmemstore = data;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK); #2;
      if (dhit) begin got = 1'b1; break; end
      if (dREN | dWEN) mem_cyc++;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL req_timeout: got no dhit for addr %h, expected dhit within 200 cycles", addr);
    end
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  // memory model: dwait held high for mem_lat cycles of each request, then one ready cycle
  initial begin
    dwait = 1'b1;
    dload = '0;
    forever begin
      @(negedge CLK);
      if (dREN | dWEN) begin
        if (rsp_cnt < mem_lat) begin
          dwait = 1'b1; dload = '0; rsp_cnt++;
        end else begin
          dwait = 1'b0; rsp_cnt = 0;
          if (dWEN) mem[daddr] = dstore;
          dload = mem.exists(daddr) ? mem[daddr] : 32'd0;
        end
      end else begin
        dwait = 1'b1; dload = '0; rsp_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK); #1;
      if (!RST) begin
        if (dhit) observe(dmemWEN ? K_WRH : K_RDH, dmemaddr, dmemload);
        if ((dREN | dWEN) && !dwait) observe(dWEN ? K_MWR : K_MRD, daddr, dstore);
        if (flushed && !flushed_d) observe(K_FL, 32'd0, 32'd0);
      end
      flushed_d = flushed;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected completion within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  mc;
    logic got;
    RST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    dmemaddr = '0; dmemstore = '0;
    mem[32'h40] = 32'hDEADBEEF;
    mem[32'h44] = 32'h44445555;
    mem[32'h08] = 32'h08080808;
    mem[32'h80] = 32'h80808080;
    mem[32'h88] = 32'h88888888;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK); #2;
    check_zero("reset");

    // read miss, clean victim, two wait cycles
    mem_lat = 2;
    push(K_MRD, 32'h40, 32'h0);
    push(K_RDH, 32'h40, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'h40, 32'h0, mc);
    chk("rd_miss_dren_cycles", 32'(mc), 32'd3);

    // write-allocate then dirty eviction by a conflicting read
    mem_lat = 1;
    push(K_MRD, 32'h04, 32'h0);
    push(K_WRH, 32'h04, 32'h0);
    do_req(1'b0, 1'b1, 32'h04, 32'h0000AAAA, mc);
    push(K_MWR, 32'h04, 32'h0000AAAA);
    push(K_MRD, 32'h44, 32'h0);
    push(K_RDH, 32'h44, 32'h44445555);
    do_req(1'b1, 1'b0, 32'h44, 32'h0, mc);
    chk("evict_mem_cycles", 32'(mc), 32'd4);

    // write hit after fill, then read back
    push(K_MRD, 32'h08, 32'h0);
    push(K_RDH, 32'h08, 32'h08080808);
    do_req(1'b1, 1'b0, 32'h08, 32'h0, mc);
    push(K_WRH, 32'h08, 32'h0);
    do_req(1'b0, 1'b1, 32'h08, 32'h00001234, mc);
    chk("wr_hit_mem_cycles", 32'(mc), 32'd0);
    push(K_RDH, 32'h08, 32'h00001234);
    do_req(1'b1, 1'b0, 32'h08, 32'h0, mc);

    // read+write together is a write; the dirty line is written back on eviction
    push(K_WRH, 32'h08, 32'h0);
    do_req(1'b1, 1'b1, 32'h08, 32'h00005555, mc);
    chk("rdwr_hit_mem_cycles", 32'(mc), 32'd0);
    push(K_MWR, 32'h08, 32'h00005555);
    push(K_MRD, 32'h88, 32'h0);
    push(K_RDH, 32'h88, 32'h88888888);
    do_req(1'b1, 1'b0, 32'h88, 32'h0, mc);

    // reset in the middle of a stalled fetch
    mem_lat = 6;
    @(posedge CLK); #1;
    dmemREN = 1'b1; dmemaddr = 32'h80;
    repeat (3) @(negedge CLK);
    #2 chk("fetch_active_before_reset", 32'(dREN), 32'd1);
    @(posedge CLK); #1;
    RST = 1'b1; dmemREN = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK); #2;
    check_zero("after_reset");
    mem_lat = 1;
    push(K_MRD, 32'h80, 32'h0);
    push(K_RDH, 32'h80, 32'h80808080);
    do_req(1'b1, 1'b0, 32'h80, 32'h0, mc);
    chk("post_reset_refetch_cycles", 32'(mc), 32'd2);

    // dirty lines at indices 1 and 15, four hits since reset
    push(K_MRD, 32'h04, 32'h0);
    push(K_WRH, 32'h04, 32'h0);
    do_req(1'b0, 1'b1, 32'h04, 32'h00001111, mc);
    push(K_MRD, 32'h3C, 32'h0);
    push(K_WRH, 32'h3C, 32'h0);
    do_req(1'b0, 1'b1, 32'h3C, 32'h00002222, mc);
    push(K_RDH, 32'h04, 32'h00001111);
    do_req(1'b1, 1'b0, 32'h04, 32'h0, mc);

    // halt beats a simultaneous hitting request
    @(posedge CLK); #1;
    halt = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h04;
    @(negedge CLK); #2;
    chk("halt_blocks_hit", 32'(dhit), 32'd0);
    push(K_MWR, 32'h04, 32'h00001111);
    push(K_MWR, 32'h3C, 32'h00002222);
    push(K_MWR, 32'h3100, 32'd4);
    push(K_FL, 32'h0, 32'h0);
    @(posedge CLK); #1;
    halt = 1'b0; dmemREN = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK); #2;
      if (flushed) begin got = 1'b1; break; end
    end
    chk("flush_completes", 32'(got), 32'd1);

    // DONE ignores requests and halt
    @(posedge CLK); #1;
    dmemREN = 1'b1; dmemaddr = 32'h04; halt = 1'b1;
    @(negedge CLK); #2;
    chk("done_no_hit", 32'(dhit), 32'd0);
    chk("done_no_mem", {30'd0, dREN, dWEN}, 32'd0);
    chk("done_flushed", 32'(flushed), 32'd1);
    @(posedge CLK); #1;
    dmemREN = 1'b0; halt = 1'b0;
    repeat (3) @(posedge CLK);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
